// File: rtl/fibo_requester.sv
// Host-side sequencer for a Fibonacci calculator: accepts an index, runs the
// calculator reset/settle/begin sequence, waits for done or a timeout, and
// returns a single response with status flags and saturating statistics.
module fibo_requester #(
  parameter int unsigned BEGIN_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_index,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_value,
  output logic        rsp_timeout,
  output logic        rsp_range_err,
  output logic        calc_reset_n,
  output logic [4:0]  calc_input_s,
  output logic        calc_begin,
  input  logic        calc_done,
  input  logic [15:0] calc_fibo_out,
  output logic [7:0]  ok_count,
  output logic [7:0]  timeout_count
);

  localparam int unsigned MAX_INDEX    = 24;
  localparam int unsigned PHASE_CYCLES = 2;
  localparam int unsigned CNT_MAX      = (TIMEOUT_CYCLES > BEGIN_CYCLES) ? TIMEOUT_CYCLES : BEGIN_CYCLES;
  localparam int unsigned CNT_W        = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRST,
    S_SETTLE,
    S_BEGIN,
    S_WAIT,
    S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               cmd_ready_q, cmd_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [15:0]        rsp_value_q, rsp_value_d;
  logic               rsp_timeout_q, rsp_timeout_d;
  logic               rsp_range_err_q, rsp_range_err_d;
  logic               calc_reset_n_q, calc_reset_n_d;
  logic [4:0]         calc_input_s_q, calc_input_s_d;
  logic               calc_begin_q, calc_begin_d;
  logic [7:0]         ok_count_q, ok_count_d;
  logic [7:0]         timeout_count_q, timeout_count_d;

  logic               accept;
  logic               in_range;
  logic               phase_last;
  logic               begin_last;
  logic               wait_last;

  assign accept     = (state_q == S_IDLE) && cmd_valid;
  assign in_range   = (cmd_index <= 5'(MAX_INDEX));
  assign phase_last = (cnt_q == CNT_W'(PHASE_CYCLES - 1));
  assign begin_last = (cnt_q == CNT_W'(BEGIN_CYCLES - 1));
  assign wait_last  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and phase counter; cnt restarts at 0 on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) state_d = in_range ? S_CRST : S_RESP;
      end
      S_CRST: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (phase_last) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (phase_last) begin
          state_d = S_BEGIN;
          cnt_d   = '0;
        end
      end
      S_BEGIN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (begin_last) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (calc_done || wait_last) begin
          state_d = S_RESP;
          cnt_d   = '0;
        end
      end
      S_RESP: begin
        cnt_d = '0;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output/datapath next values; strobes decode the upcoming state so they are registered.
  always_comb begin
    cmd_ready_d     = (state_d == S_IDLE);
    rsp_valid_d     = (state_d == S_RESP);
    calc_begin_d    = (state_d == S_BEGIN);
    calc_reset_n_d  = (state_d != S_CRST);
    calc_input_s_d  = calc_input_s_q;
    rsp_value_d     = rsp_value_q;
    rsp_timeout_d   = rsp_timeout_q;
    rsp_range_err_d = rsp_range_err_q;
    ok_count_d      = ok_count_q;
    timeout_count_d = timeout_count_q;

    if (accept) begin
      rsp_timeout_d = 1'b0;
      if (in_range) begin
        calc_input_s_d  = cmd_index;
        rsp_range_err_d = 1'b0;
      end else begin
        rsp_value_d     = '0;
        rsp_range_err_d = 1'b1;
      end
    end

    // Done takes priority over a timeout landing on the same cycle.
    if (state_q == S_WAIT) begin
      if (calc_done) begin
        rsp_value_d   = calc_fibo_out;
        rsp_timeout_d = 1'b0;
      end else if (wait_last) begin
        rsp_value_d   = '0;
        rsp_timeout_d = 1'b1;
      end
    end

    if ((state_q == S_RESP) && rsp_ready && !rsp_range_err_q) begin
      if (rsp_timeout_q) begin
        if (timeout_count_q != 8'hFF) timeout_count_d = timeout_count_q + 8'd1;
      end else begin
        if (ok_count_q != 8'hFF) ok_count_d = ok_count_q + 8'd1;
      end
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_ready_q     <= 1'b1;
      rsp_valid_q     <= 1'b0;
      rsp_value_q     <= '0;
      rsp_timeout_q   <= 1'b0;
      rsp_range_err_q <= 1'b0;
      calc_reset_n_q  <= 1'b0;
      calc_input_s_q  <= '0;
      calc_begin_q    <= 1'b0;
      ok_count_q      <= '0;
      timeout_count_q <= '0;
    end else begin
      cmd_ready_q     <= cmd_ready_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_value_q     <= rsp_value_d;
      rsp_timeout_q   <= rsp_timeout_d;
      rsp_range_err_q <= rsp_range_err_d;
      calc_reset_n_q  <= calc_reset_n_d;
      calc_input_s_q  <= calc_input_s_d;
      calc_begin_q    <= calc_begin_d;
      ok_count_q      <= ok_count_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_value     = rsp_value_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign rsp_range_err = rsp_range_err_q;
  assign calc_reset_n  = calc_reset_n_q;
  assign calc_input_s  = calc_input_s_q;
  assign calc_begin    = calc_begin_q;
  assign ok_count      = ok_count_q;
  assign timeout_count = timeout_count_q;

endmodule

// File: tb/tb_fibo_requester.sv
// Directed bench: instance A talks to a behavioural Fibonacci calculator,
// instance B has a short timeout and a calculator that never finishes.
module tb_fibo_requester;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Instance A signals
  logic        a_cmd_valid, a_cmd_ready, a_rsp_valid, a_rsp_ready;
  logic [4:0]  a_cmd_index, a_calc_input_s;
  logic [15:0] a_rsp_value, a_calc_fibo_out;
  logic        a_rsp_timeout, a_rsp_range_err, a_calc_reset_n, a_calc_begin, a_calc_done;
  logic [7:0]  a_ok_count, a_timeout_count;
  logic        force_done;

  // Instance B signals
  logic        b_cmd_valid, b_cmd_ready, b_rsp_valid, b_rsp_ready;
  logic [4:0]  b_cmd_index, b_calc_input_s;
  logic [15:0] b_rsp_value;
  logic        b_rsp_timeout, b_rsp_range_err, b_calc_reset_n, b_calc_begin;
  logic [7:0]  b_ok_count, b_timeout_count;

  fibo_requester u_a (
    .clk(clk), .reset(reset),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_index(a_cmd_index),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_value(a_rsp_value),
    .rsp_timeout(a_rsp_timeout), .rsp_range_err(a_rsp_range_err),
    .calc_reset_n(a_calc_reset_n), .calc_input_s(a_calc_input_s), .calc_begin(a_calc_begin),
    .calc_done(a_calc_done | force_done), .calc_fibo_out(a_calc_fibo_out),
    .ok_count(a_ok_count), .timeout_count(a_timeout_count)
  );

  fibo_requester #(.BEGIN_CYCLES(2), .TIMEOUT_CYCLES(16)) u_b (
    .clk(clk), .reset(reset),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_index(b_cmd_index),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_value(b_rsp_value),
    .rsp_timeout(b_rsp_timeout), .rsp_range_err(b_rsp_range_err),
    .calc_reset_n(b_calc_reset_n), .calc_input_s(b_calc_input_s), .calc_begin(b_calc_begin),
    .calc_done(1'b0), .calc_fibo_out(16'hBEEF),
    .ok_count(b_ok_count), .timeout_count(b_timeout_count)
  );

  // Behavioural iterative calculator for instance A: fib(0)=0, fib(1)=1.
  logic        m_busy;
  logic [4:0]  m_k;
  logic [16:0] m_a, m_b;
  always_ff @(posedge clk) begin
    if (!a_calc_reset_n) begin
      m_busy <= 1'b0; a_calc_done <= 1'b0; m_k <= '0;
      m_a <= '0; m_b <= '0; a_calc_fibo_out <= '0;
    end else if (a_calc_begin && !m_busy) begin
      m_busy <= 1'b1; a_calc_done <= 1'b0; m_k <= a_calc_input_s;
      m_a <= 17'd0; m_b <= 17'd1;
    end else if (m_busy) begin
      if (m_k == 5'd0) begin
        a_calc_done <= 1'b1; a_calc_fibo_out <= m_a[15:0]; m_busy <= 1'b0;
      end else begin
        m_a <= m_b; m_b <= m_a + m_b; m_k <= m_k - 5'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic wait_a_rsp(input string tag);
    int n = 0;
    while (!a_rsp_valid && n < 300) begin
      @(negedge clk); n++;
    end
    check({tag, "_valid"}, 32'(a_rsp_valid), 32'd1);
  endtask

  // Full request on A with immediate handshake.
  task automatic do_req_a(input logic [4:0] idx, input logic [15:0] expv, input string tag);
    check({tag, "_cmd_ready"}, 32'(a_cmd_ready), 32'd1);
    a_cmd_index = idx; a_cmd_valid = 1'b1;
    @(negedge clk);
    a_cmd_valid = 1'b0;
    wait_a_rsp(tag);
    check({tag, "_value"}, 32'(a_rsp_value), 32'(expv));
    check({tag, "_timeout"}, 32'(a_rsp_timeout), 32'd0);
    check({tag, "_range"}, 32'(a_rsp_range_err), 32'd0);
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
    check({tag, "_ready_after"}, 32'(a_cmd_ready), 32'd1);
    check({tag, "_valid_after"}, 32'(a_rsp_valid), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1;
    a_cmd_valid = 1'b1; a_cmd_index = 5'd3; a_rsp_ready = 1'b0; force_done = 1'b0;
    b_cmd_valid = 1'b1; b_cmd_index = 5'd3; b_rsp_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values with cmd_valid asserted.
    check("rst_cmd_ready", 32'(a_cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("rst_rsp_value", 32'(a_rsp_value), 32'd0);
    check("rst_flags", 32'({a_rsp_timeout, a_rsp_range_err}), 32'd0);
    check("rst_calc_reset_n", 32'(a_calc_reset_n), 32'd0);
    check("rst_calc_input_s", 32'(a_calc_input_s), 32'd0);
    check("rst_calc_begin", 32'(a_calc_begin), 32'd0);
    check("rst_counts", 32'({a_ok_count, a_timeout_count}), 32'd0);
    check("rst_b_ready", 32'(b_cmd_ready), 32'd1);
    a_cmd_valid = 1'b0; b_cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rel_calc_reset_n", 32'(a_calc_reset_n), 32'd1);
    check("rel_cmd_ready", 32'(a_cmd_ready), 32'd1);

    // Back-to-back requests.
    do_req_a(5'd5, 16'd5, "fib5");
    do_req_a(5'd9, 16'd34, "fib9");
    do_req_a(5'd12, 16'd144, "fib12");
    check("ok_count_3", 32'(a_ok_count), 32'd3);

    // Cycle-exact sequence for index 10, with spurious done before WAIT.
    a_cmd_index = 5'd10; a_cmd_valid = 1'b1;
    @(negedge clk);
    a_cmd_valid = 1'b0;
    force_done = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      if (c == 6) force_done = 1'b0;
      check($sformatf("seq_rn_%0d", c), 32'(a_calc_reset_n), 32'(c >= 3));
      check($sformatf("seq_bg_%0d", c), 32'(a_calc_begin), 32'((c == 5) || (c == 6)));
      check($sformatf("seq_in_%0d", c), 32'(a_calc_input_s), 32'd10);
      check($sformatf("seq_rv_%0d", c), 32'(a_rsp_valid), 32'd0);
      @(negedge clk);
    end
    k = 0;
    while (!a_rsp_valid && k < 300) begin
      check("seq_in_wait", 32'(a_calc_input_s), 32'd10);
      @(negedge clk); k++;
    end
    check("seq_valid", 32'(a_rsp_valid), 32'd1);
    check("seq_value", 32'(a_rsp_value), 32'd55);
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;

    // Index 24 with a 10-cycle stall on rsp_ready.
    a_cmd_index = 5'd24; a_cmd_valid = 1'b1;
    @(negedge clk);
    a_cmd_valid = 1'b0;
    wait_a_rsp("stall");
    for (int c = 0; c < 10; c++) begin
      check("stall_valid", 32'(a_rsp_valid), 32'd1);
      check("stall_value", 32'(a_rsp_value), 32'd46368);
      check("stall_cmd_ready", 32'(a_cmd_ready), 32'd0);
      @(negedge clk);
    end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
    check("stall_ready_after", 32'(a_cmd_ready), 32'd1);
    check("ok_count_5", 32'(a_ok_count), 32'd5);

    // Index 25: range error, no calculator activity.
    a_cmd_index = 5'd25; a_cmd_valid = 1'b1;
    @(negedge clk);
    a_cmd_valid = 1'b0;
    check("rng_valid", 32'(a_rsp_valid), 32'd1);
    check("rng_err", 32'(a_rsp_range_err), 32'd1);
    check("rng_timeout", 32'(a_rsp_timeout), 32'd0);
    check("rng_value", 32'(a_rsp_value), 32'd0);
    check("rng_calc_reset_n", 32'(a_calc_reset_n), 32'd1);
    check("rng_calc_begin", 32'(a_calc_begin), 32'd0);
    check("rng_input_s", 32'(a_calc_input_s), 32'd24);
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
    check("rng_calc_reset_n2", 32'(a_calc_reset_n), 32'd1);
    check("rng_counts", 32'({a_ok_count, a_timeout_count}), 32'({8'd5, 8'd0}));

    // Reset pulsed during WAIT aborts the request.
    a_cmd_index = 5'd20; a_cmd_valid = 1'b1;
    @(negedge clk);
    a_cmd_valid = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_cmd_ready", 32'(a_cmd_ready), 32'd1);
    check("mid_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("mid_calc_reset_n", 32'(a_calc_reset_n), 32'd0);
    check("mid_calc_input_s", 32'(a_calc_input_s), 32'd0);
    check("mid_calc_begin", 32'(a_calc_begin), 32'd0);
    check("mid_counts", 32'({a_ok_count, a_timeout_count}), 32'd0);
    check("mid_value", 32'(a_rsp_value), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rel_calc_reset_n", 32'(a_calc_reset_n), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("mid_no_rsp", 32'(a_rsp_valid), 32'd0);
    end
    do_req_a(5'd7, 16'd13, "fib7");
    check("ok_count_1", 32'(a_ok_count), 32'd1);

    // Timeout on B: 16 WAIT cycles, response in cycle N+23.
    b_cmd_index = 5'd3; b_cmd_valid = 1'b1;
    @(negedge clk);
    b_cmd_valid = 1'b0;
    k = 1;
    while (!b_rsp_valid && k < 100) begin
      @(negedge clk); k++;
    end
    check("tmo_latency", 32'(k), 32'd23);
    check("tmo_flag", 32'(b_rsp_timeout), 32'd1);
    check("tmo_value", 32'(b_rsp_value), 32'd0);
    check("tmo_range", 32'(b_rsp_range_err), 32'd0);
    b_rsp_ready = 1'b1;
    @(negedge clk);
    b_rsp_ready = 1'b0;
    check("tmo_count", 32'(b_timeout_count), 32'd1);
    check("tmo_ok_count", 32'(b_ok_count), 32'd0);
    check("tmo_ready_after", 32'(b_cmd_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fibo_requester.md
FIBO_REQUESTER -- requirements
Module: fibo_requester

Interface
REQ-001 SHALL have parameter BEGIN_CYCLES, default 2: number of cycles calc_begin is held high per request.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum cycles spent in WAIT before a timeout response.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports cmd_valid (input, 1), cmd_ready (output, 1) and cmd_index (input, 5): host request handshake and Fibonacci index.
REQ-006 SHALL have ports rsp_valid (output, 1) and rsp_ready (input, 1): host response handshake.
REQ-007 SHALL have port rsp_value, output, 16: result value.
REQ-008 SHALL have ports rsp_timeout (output, 1) and rsp_range_err (output, 1): response status flags.
REQ-009 SHALL have ports calc_reset_n (output, 1), calc_input_s (output, 5) and calc_begin (output, 1): drive the calculator's reset_n, input_s and begin_fibo.
REQ-010 SHALL have ports calc_done (input, 1) and calc_fibo_out (input, 16): calculator result, synchronous to clk.
REQ-011 SHALL have ports ok_count (output, 8) and timeout_count (output, 8): saturating statistics counters.

Function
REQ-012 SHALL implement states IDLE, CRST, SETTLE, BEGIN, WAIT and RESP.
REQ-013 SHALL assert cmd_ready only in IDLE; a command is accepted on the edge where cmd_valid and cmd_ready are both 1 (edge N).
REQ-014 SHALL, on accepting an index > 24, go directly to RESP with rsp_range_err=1 and rsp_value=0, leaving all calc_* outputs unchanged.
REQ-015 SHALL, on accepting an index <= 24, latch it and drive calc_input_s from it, held stable through the end of WAIT.
REQ-016 SHALL spend cycles N+1..N+2 in CRST with calc_reset_n=0, then cycles N+3..N+4 in SETTLE with calc_reset_n=1 and calc_begin=0.
REQ-017 SHALL spend BEGIN_CYCLES cycles in BEGIN with calc_begin=1 (N+5..N+6 at the default), then enter WAIT with calc_begin=0.
REQ-018 SHALL sample calc_done only in WAIT; calc_done high during CRST, SETTLE or BEGIN is ignored.
REQ-019 SHALL, on the first WAIT cycle with calc_done=1, capture calc_fibo_out into rsp_value and enter RESP on the next edge with rsp_timeout=0.
REQ-020 SHALL count WAIT cycles; if the count reaches TIMEOUT_CYCLES without calc_done, it enters RESP with rsp_timeout=1 and rsp_value=0.
REQ-021 SHALL hold rsp_valid=1 in RESP, with rsp_value and the flags stable, until rsp_ready=1, then return to IDLE on that edge.
REQ-022 SHALL accept a new command no earlier than the cycle after the response handshake; there is no pipelining.
REQ-023 SHALL treat calc_done and timeout completing on the same cycle as done (done wins).
REQ-024 SHALL increment ok_count on each successful response handshake and timeout_count on each timeout response handshake; both saturate at 255 and range errors count in neither.
REQ-025 SHALL keep the calculator out of reset (calc_reset_n=1) in IDLE, WAIT and RESP.

Reset
REQ-026 SHALL, while reset=1, force state IDLE with cmd_ready=1, rsp_valid=0, rsp_value=0, rsp_timeout=0, rsp_range_err=0, calc_reset_n=0, calc_input_s=0, calc_begin=0, ok_count=0, timeout_count=0 and the WAIT counter at 0.
REQ-027 SHALL ignore cmd_valid while reset=1.
REQ-028 SHALL, when reset asserts mid-operation, abort the operation and discard any pending response; calc_reset_n returns to 1 on the first edge after release.

Verification
REQ-029 SHALL be verified by: index 5, 9, 12 sent back-to-back with the real calculator -> rsp_value 5, 34, 144, flags 0, ok_count=3.
REQ-030 SHALL be verified by: index 24 -> rsp_value 46368; index 25 -> rsp_range_err=1 and rsp_valid one cycle after accept, with calc_reset_n and calc_begin never toggling.
REQ-031 SHALL be verified by: TIMEOUT_CYCLES=16 and calc_done tied 0 -> rsp_valid after 16 WAIT cycles, rsp_timeout=1, rsp_value=0, timeout_count=1.
REQ-032 SHALL be verified by: a cycle check at accept edge N -> calc_reset_n low at N+1..N+2, calc_begin high at N+5..N+6, calc_input_s equal to the index from N+1 through done.
REQ-033 SHALL be verified by: rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_value stable and cmd_ready=0 throughout; cmd_ready=1 the cycle after the handshake.
REQ-034 SHALL be verified by: reset pulsed during WAIT -> all outputs at reset values, no rsp_valid, and the next index 7 request returns 13.
